// File: rtl/exibidor_saida_if.sv
// Value/display bundle between the calculator output register and exibidor_saida.
// master drives valor; slave (the display block) drives the BCD, busy flag and LED pins.
interface exibidor_saida_if;
    logic [7:0]  valor;
    logic [11:0] bcd;
    logic        busy;
    logic [6:0]  seg;
    logic [2:0]  an;

    modport master (output valor, input bcd, busy, seg, an);
    modport slave  (input valor, output bcd, busy, seg, an);
endinterface

// File: rtl/exibidor_saida.sv
// Converts the 8-bit calculator result to BCD (double dabble, one bit per cycle)
// and multiplexes it onto a 3-digit active-low 7-segment display.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zeros on hundreds/tens.
module exibidor_saida #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic             clk,
    input  logic             reset,
    exibidor_saida_if.slave  bus
);

    localparam int unsigned VAL_W  = 8;
    localparam int unsigned BCD_W  = 12;
    localparam int unsigned ITER_W = 3;
    localparam int unsigned CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0]       SEG_OFF  = 7'b1111111;
    localparam logic [6:0]       SEG_ZERO = 7'b1000000;

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t             state_q, state_d;
    logic [VAL_W-1:0]   cap_q, cap_d;
    logic               force_q, force_d;
    logic [ITER_W-1:0]  iter_q, iter_d;
    logic [BCD_W-1:0]   work_bcd_q, work_bcd_d;
    logic [VAL_W-1:0]   work_bin_q, work_bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               busy_q, busy_d;

    logic [CNT_W-1:0]   ref_q, ref_d;
    logic [1:0]         digit_q, digit_d;
    logic [2:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;

    logic [BCD_W-2:0]   adj_c;
    logic [3:0]         nib_c;
    logic               blank_c;

    // Add-3 correction on every nibble >= 5; the top bit is dropped by the following shift.
    function automatic logic [BCD_W-2:0] dabble_adj(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] t;
        t = b;
        for (int i = 0; i < 3; i++) begin
            if (t[i*4 +: 4] >= 4'd5) begin
                t[i*4 +: 4] = t[i*4 +: 4] + 4'd3;
            end
        end
        return t[BCD_W-2:0];
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

    assign adj_c = dabble_adj(work_bcd_q);

    // Conversion FSM: capture on change/force, then eight shift-and-correct steps.
    always_comb begin
        state_d    = state_q;
        cap_d      = cap_q;
        force_d    = force_q;
        iter_d     = iter_q;
        work_bcd_d = work_bcd_q;
        work_bin_d = work_bin_q;
        bcd_d      = bcd_q;
        busy_d     = busy_q;

        case (state_q)
            IDLE: begin
                if ((bus.valor != cap_q) || force_q) begin
                    cap_d      = bus.valor;
                    force_d    = 1'b0;
                    iter_d     = '0;
                    work_bin_d = bus.valor;
                    work_bcd_d = '0;
                    busy_d     = 1'b1;
                    state_d    = CONV;
                end
            end
            CONV: begin
                {work_bcd_d, work_bin_d} = {adj_c, work_bin_q, 1'b0};
                iter_d = iter_q + ITER_W'(1);
                if (iter_q == ITER_W'(7)) begin
                    bcd_d   = {adj_c, work_bin_q[VAL_W-1]};
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Digit select for the currently scanned position.
    always_comb begin
        nib_c   = bcd_q[3:0];
        blank_c = 1'b0;
        an_d    = 3'b110;
        case (digit_q)
            2'd1: begin
                nib_c = bcd_q[7:4];
                an_d  = 3'b101;
`ifdef LEADING_ZERO_BLANK_EN
                blank_c = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
`endif
            end
            2'd2: begin
                nib_c = bcd_q[11:8];
                an_d  = 3'b011;
`ifdef LEADING_ZERO_BLANK_EN
                blank_c = (bcd_q[11:8] == 4'd0);
`endif
            end
            default: begin
                nib_c = bcd_q[3:0];
                an_d  = 3'b110;
            end
        endcase
        seg_d = blank_c ? SEG_OFF : seg_decode(nib_c);
    end

    // Refresh divider: each digit stays enabled for REFRESH_DIV cycles.
    always_comb begin
        ref_d   = ref_q + CNT_W'(1);
        digit_d = digit_q;
        if (ref_q == CNT_LAST) begin
            ref_d   = '0;
            digit_d = (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cap_q      <= '0;
            force_q    <= 1'b1;
            iter_q     <= '0;
            work_bcd_q <= '0;
            work_bin_q <= '0;
            bcd_q      <= '0;
            busy_q     <= 1'b0;
            ref_q      <= '0;
            digit_q    <= 2'd0;
            an_q       <= 3'b110;
            seg_q      <= SEG_ZERO;
        end else begin
            state_q    <= state_d;
            cap_q      <= cap_d;
            force_q    <= force_d;
            iter_q     <= iter_d;
            work_bcd_q <= work_bcd_d;
            work_bin_q <= work_bin_d;
            bcd_q      <= bcd_d;
            busy_q     <= busy_d;
            ref_q      <= ref_d;
            digit_q    <= digit_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign bus.bcd  = bcd_q;
    assign bus.busy = busy_q;
    assign bus.an   = an_q;
    assign bus.seg  = seg_q;

endmodule
